// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Shared opcode and FSM state types for the multicycle ALU, |
// |            plus the helper that selects an operation's first carry.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NOR   = 3'b011,
      OP_ADD   = 3'b100,
      OP_SUB   = 3'b101,
      OP_SLL1  = 3'b110,
      OP_PASSB = 3'b111
   } opsel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // SUB is computed as A + ~B + ~Cin, so its first carry is the inverted
   // borrow-in. Every other op (including SLL1) starts from Cin itself.
   function automatic logic init_carry(input opsel_e op, input logic cin);
      return (op == OP_SUB) ? ~cin : cin;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_slice                                                 |
// | Purpose  : Combinational W-bit ALU slice. The caller supplies the    |
// |            carry chained from the previous slice.                    |
// | Ports    : i_a, i_b    W-bit operand chunks                          |
// |            i_cin       incoming carry / shift-in bit                 |
// |            i_opsel     opcode                                        |
// |            o_result    W-bit result chunk                            |
// |            o_cout      carry out of the slice (A MSB for SLL1)       |
// |            o_cmsb      carry into the slice MSB (overflow detection) |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_slice #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   input  logic [2:0]   i_opsel,
   output logic [W-1:0] o_result,
   output logic         o_cout,
   output logic         o_cmsb
);
   import alu_pkg::*;

   logic [W-1:0] w_b_eff;
   logic [W:0]   w_sum;

   always_comb begin
      w_b_eff  = (i_opsel == OP_SUB) ? ~i_b : i_b;
      w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{W{1'b0}}, i_cin};
      o_result = '0;
      o_cout   = 1'b0;
      o_cmsb   = 1'b0;
      case (i_opsel)
         OP_AND:   o_result = i_a & i_b;
         OP_OR:    o_result = i_a | i_b;
         OP_XOR:   o_result = i_a ^ i_b;
         OP_NOR:   o_result = ~(i_a | i_b);
         OP_ADD, OP_SUB: begin
            o_result = w_sum[W-1:0];
            o_cout   = w_sum[W];
            // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out
            // without a second adder. Also valid when W == 1.
            o_cmsb   = i_a[W-1] ^ w_b_eff[W-1] ^ w_sum[W-1];
         end
         OP_SLL1: begin
            o_result = (i_a << 1) | W'(i_cin);
            o_cout   = i_a[W-1];
         end
         OP_PASSB: o_result = i_b;
         default:  o_result = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_multicycle                                            |
// | Purpose  : WIDTH-bit ALU processed SLICE bits per clock. The carry   |
// |            between slices is held in a register. Operations enter    |
// |            and results leave through valid/ready handshakes.         |
// | Ports    : clk, rst                 clock, sync active-high reset    |
// |            i_in_valid / o_in_ready  operation handshake              |
// |            i_a, i_b, i_cin, i_opsel operands, carry-in, opcode       |
// |            o_out_valid/i_out_ready  result handshake                 |
// |            o_result, o_cout, o_zero, o_ovf  result and flags         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_multicycle #(
   parameter int WIDTH = 128,
   parameter int SLICE = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic [2:0]       i_opsel,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_zero,
   output logic             o_ovf
);
   import alu_pkg::*;

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NSLICE - 1);

   state_e           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   opsel_e           r_op;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;
   logic             r_ovf;

   logic [SLICE-1:0] w_a_chunk;
   logic [SLICE-1:0] w_b_chunk;
   logic [SLICE-1:0] w_slice_res;
   logic             w_slice_cout;
   logic             w_slice_cmsb;
   logic [WIDTH-1:0] w_result_next;

   // Operand chunk selection by slice counter.
   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (r_cnt == CNT_W'(k)) begin
            w_a_chunk = r_a[k*SLICE +: SLICE];
            w_b_chunk = r_b[k*SLICE +: SLICE];
         end
      end
   end

   alu_slice #(
      .W(SLICE)
   ) u_slice (
      .i_a      (w_a_chunk),
      .i_b      (w_b_chunk),
      .i_cin    (r_carry),
      .i_opsel  (r_op),
      .o_result (w_slice_res),
      .o_cout   (w_slice_cout),
      .o_cmsb   (w_slice_cmsb)
   );

   // Result register with the current chunk merged in. Kept separate from
   // the operand mux so there is no apparent loop through the slice.
   always_comb begin
      w_result_next = r_result;
      for (int k = 0; k < NSLICE; k++) begin
         if (r_cnt == CNT_W'(k)) begin
            w_result_next[k*SLICE +: SLICE] = w_slice_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_AND;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_cout      <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // r_in_ready is 1 throughout IDLE, so i_in_valid alone
               // completes the handshake.
               if (i_in_valid) begin
                  r_a        <= i_a;
                  r_b        <= i_b;
                  r_op       <= opsel_e'(i_opsel);
                  r_carry    <= init_carry(opsel_e'(i_opsel), i_cin);
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               r_result <= w_result_next;
               r_carry  <= w_slice_cout;
               // Exit on an explicit count match. Wrap-around would alias
               // when NSLICE is not a power of two.
               if (r_cnt == c_last_cnt) begin
                  r_cout      <= w_slice_cout;
                  r_ovf       <= ((r_op == OP_ADD) || (r_op == OP_SUB))
                                 && (w_slice_cmsb ^ w_slice_cout);
                  r_zero      <= (w_result_next == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_cout      = r_cout;
   assign o_zero      = r_zero;
   assign o_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_multicycle                                         |
// | Purpose  : Self-checking bench for alu_multicycle (WIDTH=128,        |
// |            SLICE=32) against a whole-word arithmetic reference.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_multicycle;

   localparam int WIDTH  = 128;
   localparam int SLICE  = 32;
   localparam int NSLICE = WIDTH / SLICE;
   localparam int LAT    = NSLICE + 1;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             cout;
      logic             zero;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_cin;
   logic [2:0]       i_opsel;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_cout;
   logic             o_zero;
   logic             o_ovf;

   int n_checks = 0;
   int n_errors = 0;

   alu_multicycle #(
      .WIDTH(WIDTH),
      .SLICE(SLICE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_cin       (i_cin),
      .i_opsel     (i_opsel),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_result    (o_result),
      .o_cout      (o_cout),
      .o_zero      (o_zero),
      .o_ovf       (o_ovf)
   );

   always #5 clk = ~clk;

   // Whole-word reference: SUB is a true signed/unsigned difference,
   // overflow uses the operand/result sign rule.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic [2:0] op);
      exp_t e;
      logic [WIDTH:0] s;
      e.res  = '0;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      case (op)
         3'b000: e.res = a & b;
         3'b001: e.res = a | b;
         3'b010: e.res = a ^ b;
         3'b011: e.res = ~(a | b);
         3'b100: begin
            s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            e.res  = s[WIDTH-1:0];
            e.cout = s[WIDTH];
            e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b101: begin
            s      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            e.res  = s[WIDTH-1:0];
            e.cout = ~s[WIDTH];
            e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b110: begin
            e.res  = {a[WIDTH-2:0], cin};
            e.cout = a[WIDTH-1];
         end
         default: e.res = b;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0: w = '0;
         1: w = '1;
         2: w = {1'b1, {(WIDTH-1){1'b0}}};
         3: w = {1'b0, {(WIDTH-1){1'b1}}};
         default: ;
      endcase
      return w;
   endfunction

   // Drive one operation, wait for its result. Leaves time at posedge+1.
   task automatic do_issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic [2:0] op,
                           output int cycles, output bit tmo);
      int w;
      i_a = a; i_b = b; i_cin = cin; i_opsel = op; i_in_valid = 1'b1;
      w = 0;
      while (!o_in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      // Scramble inputs: the captured copy must be what gets processed.
      i_in_valid = 1'b0;
      i_a = rand_word(); i_b = rand_word(); i_cin = 1'($urandom()); i_opsel = 3'($urandom());
      cycles = 1;
      while (!o_out_valid && cycles < 50) begin
         @(posedge clk); #1; cycles++;
      end
      tmo = !o_out_valid || (w >= 50);
   endtask

   task automatic collect();
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_a = '0; i_b = '0; i_cin = 1'b0; i_opsel = 3'b000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", o_in_ready, o_out_valid);
      end
      n_checks++;
      if (o_result !== '0 || o_cout !== 1'b0 || o_zero !== 1'b0 || o_ovf !== 1'b0) begin
         n_errors++; $display("FAIL reset_out: result=%h c/z/v=%b%b%b required 0/000", o_result, o_cout, o_zero, o_ovf);
      end
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] va[7];
      logic [WIDTH-1:0] vb[7];
      logic             vc[7];
      logic [2:0]       vo[7];
      exp_t e;
      int cyc;
      bit tmo;
      va[0] = 128'hFFFF_FFFF;        vb[0] = 128'd1; vc[0] = 1'b0; vo[0] = 3'b100;
      va[1] = '1;                    vb[1] = 128'd1; vc[1] = 1'b0; vo[1] = 3'b100;
      va[2] = {1'b1, 127'd0};        vb[2] = 128'd1; vc[2] = 1'b0; vo[2] = 3'b101;
      va[3] = '0;                    vb[3] = '0;     vc[3] = 1'b1; vo[3] = 3'b101;
      va[4] = 128'h8000_0000;        vb[4] = '0;     vc[4] = 1'b1; vo[4] = 3'b110;
      va[5] = {1'b0, {127{1'b1}}};   vb[5] = 128'd1; vc[5] = 1'b0; vo[5] = 3'b100;
      va[6] = 128'h1234_5678_9ABC;   vb[6] = va[6];  vc[6] = 1'b1; vo[6] = 3'b010;
      for (int i = 0; i < 7; i++) begin
         e = model(va[i], vb[i], vc[i], vo[i]);
         do_issue(va[i], vb[i], vc[i], vo[i], cyc, tmo);
         n_checks++;
         if (tmo || cyc != LAT) begin
            n_errors++; $display("FAIL dir%0d_latency: cycles=%0d timeout=%0b required %0d", i, cyc, tmo, LAT);
         end
         n_checks++;
         if (o_result !== e.res) begin
            n_errors++; $display("FAIL dir%0d_result: got %h required %h", i, o_result, e.res);
         end
         n_checks++;
         if ({o_cout, o_zero, o_ovf} !== {e.cout, e.zero, e.ovf}) begin
            n_errors++; $display("FAIL dir%0d_flags: c/z/v got %b%b%b required %b%b%b", i,
                                 o_cout, o_zero, o_ovf, e.cout, e.zero, e.ovf);
         end
         collect();
         n_checks++;
         if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
            n_errors++; $display("FAIL dir%0d_release: in_ready=%b out_valid=%b required 1/0", i, o_in_ready, o_out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      logic cin;
      logic [2:0] op;
      exp_t e;
      int cyc;
      bit tmo;
      for (int i = 0; i < 40; i++) begin
         a = rand_word(); b = rand_word(); cin = 1'($urandom()); op = 3'($urandom());
         e = model(a, b, cin, op);
         do_issue(a, b, cin, op, cyc, tmo);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         n_checks++;
         if (tmo || o_result !== e.res || {o_cout, o_zero, o_ovf} !== {e.cout, e.zero, e.ovf}) begin
            n_errors++; $display("FAIL rand%0d_op%0d: got %h c/z/v=%b%b%b required %h c/z/v=%b%b%b tmo=%0b",
                                 i, op, o_result, o_cout, o_zero, o_ovf, e.res, e.cout, e.zero, e.ovf, tmo);
         end
         collect();
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] a, b;
      exp_t e;
      int cyc;
      bit tmo;
      a = rand_word(); b = rand_word();
      e = model(a, b, 1'b1, 3'b101);
      do_issue(a, b, 1'b1, 3'b101, cyc, tmo);
      n_checks++;
      if (tmo) begin
         n_errors++; $display("FAIL bp_timeout: out_valid never rose");
      end
      i_out_ready = 1'b0;
      i_in_valid = 1'b1; i_a = ~a; i_b = a; i_opsel = 3'b100;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_result !== e.res ||
             {o_cout, o_zero, o_ovf} !== {e.cout, e.zero, e.ovf}) begin
            n_errors++; $display("FAIL bp_hold%0d: ov=%b ir=%b res=%h cz v=%b%b%b required 1/0 %h %b%b%b",
                                 k, o_out_valid, o_in_ready, o_result, o_cout, o_zero, o_ovf,
                                 e.res, e.cout, e.zero, e.ovf);
         end
         @(posedge clk); #1;
      end
      i_in_valid = 1'b0;
      collect();
      n_checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
         n_errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", o_in_ready, o_out_valid);
      end
      n_checks++;
      if (o_result !== e.res || o_cout !== e.cout) begin
         n_errors++; $display("FAIL bp_after_hs: result=%h cout=%b required %h %b", o_result, o_cout, e.res, e.cout);
      end
   endtask

   task automatic test_reset_mid_busy();
      exp_t e;
      int cyc;
      bit tmo;
      i_a = '1; i_b = 128'h5; i_cin = 1'b0; i_opsel = 3'b100; i_in_valid = 1'b1;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_result !== '0 ||
          o_cout !== 1'b0 || o_zero !== 1'b0 || o_ovf !== 1'b0) begin
         n_errors++; $display("FAIL midreset: ir=%b ov=%b res=%h c/z/v=%b%b%b required 1 0 0 000",
                              o_in_ready, o_out_valid, o_result, o_cout, o_zero, o_ovf);
      end
      e = model(128'hF0, 128'h3C, 1'b0, 3'b000);
      do_issue(128'hF0, 128'h3C, 1'b0, 3'b000, cyc, tmo);
      n_checks++;
      if (tmo || cyc != LAT || o_result !== e.res || o_result !== 128'h30) begin
         n_errors++; $display("FAIL post_reset_and: res=%h cycles=%0d required %h at %0d", o_result, cyc, e.res, LAT);
      end
      collect();
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      int   hs[$];
      exp_t e;
      bit   took;
      i_out_ready = 1'b1;
      i_a = rand_word(); i_b = rand_word(); i_cin = 1'($urandom()); i_opsel = 3'($urandom());
      i_in_valid = 1'b1;
      for (int cyc = 0; cyc < 52; cyc++) begin
         took = 1'b0;
         if (cyc == 40) i_in_valid = 1'b0;
         if (o_out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++; $display("FAIL b2b_extra: unexpected result %h", o_result);
            end else begin
               e = q.pop_front();
               if (o_result !== e.res || {o_cout, o_zero, o_ovf} !== {e.cout, e.zero, e.ovf}) begin
                  n_errors++; $display("FAIL b2b_result: got %h %b%b%b required %h %b%b%b",
                                       o_result, o_cout, o_zero, o_ovf, e.res, e.cout, e.zero, e.ovf);
               end
            end
         end
         if (o_in_ready && i_in_valid) begin
            q.push_back(model(i_a, i_b, i_cin, i_opsel));
            hs.push_back(cyc);
            took = 1'b1;
         end
         @(posedge clk); #1;
         if (took) begin
            i_a = rand_word(); i_b = rand_word(); i_cin = 1'($urandom()); i_opsel = 3'($urandom());
         end
      end
      i_out_ready = 1'b0;
      n_checks++;
      if (q.size() != 0 || hs.size() < 6) begin
         n_errors++; $display("FAIL b2b_count: pending=%0d issued=%0d required 0 and >=6", q.size(), hs.size());
      end
      for (int i = 1; i < hs.size(); i++) begin
         n_checks++;
         if (hs[i] - hs[i-1] != NSLICE + 2) begin
            n_errors++; $display("FAIL b2b_interval%0d: got %0d required %0d", i, hs[i] - hs[i-1], NSLICE + 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_busy();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
